// File: rtl/svi_scalar_reader_if.sv
// -----------------------------------------------------------------------------
// I -- SVI scalar-output interface.
//   Carries three 1-bit scalars z, y, x driven by upstream modules from
//   always_ff processes.
//   Modports:
//     D : driver side, z/y/x are outputs.
//     R : read-only side, z/y/x are inputs (used by svi_scalar_reader).
// -----------------------------------------------------------------------------
interface I;
    logic z;
    logic y;
    logic x;

    modport D (output z, output y, output x);
    modport R (input z, input y, input x);
endinterface

// File: rtl/svi_scalar_reader.sv
// -----------------------------------------------------------------------------
// svi_scalar_reader -- change detector for the SVI scalar interface.
//   Samples {z,y,x} through a read-only modport, emits one event per change
//   into a small FIFO (valid/ready output) and keeps per-bit saturating toggle
//   counters plus a sticky overflow flag for dropped events.
//
// Parameters:
//   DEPTH  event FIFO depth (power of two, >= 2)
//   CNT_W  toggle counter width (>= 2)
//
// Ports:
//   i_clk        clock, rising edge
//   i_srst       synchronous active-high reset
//   p            I.R modport, supplies p.z / p.y / p.x
//   i_en         sampling enable
//   i_clr        synchronous clear of counters and o_overflow
//   o_evt_valid  FIFO non-empty
//   i_evt_ready  consumer accepts head event
//   o_evt_data   head event {prev_z,prev_y,prev_x,cur_z,cur_y,cur_x}
//   o_cnt_z/y/x  saturating toggle counters
//   o_overflow   sticky: an event was dropped on a full FIFO
//
// Build option:
//   SVI_READER_COUNT_EN  when defined, the toggle counters are built; when
//                        undefined the counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module svi_scalar_reader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_srst,
    I.R                      p,
    input  logic             i_en,
    input  logic             i_clr,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [5:0]       o_evt_data,
    output logic [CNT_W-1:0] o_cnt_z,
    output logic [CNT_W-1:0] o_cnt_y,
    output logic [CNT_W-1:0] o_cnt_x,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t state_reg, state_next;
    logic   do_prime, do_compare;

    logic [2:0]  s_reg;
    logic [2:0]  cur;
    logic [2:0]  diff;
    logic        evt;
    logic [5:0]  evt_data;

    logic [AW:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0] level;
    logic        empty, full, pop, push, drop;
    logic [5:0]  mem [DEPTH];
    logic [5:0]  head_reg;
    logic        overflow_reg;

    logic [2:0][CNT_W-1:0] cnt_bus;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_srst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_en) state_next = PRIME;
            PRIME:   state_next = i_en ? RUN : IDLE;
            RUN:     if (!i_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Leaving RUN suppresses that cycle's compare; s is re-primed on return.
    always_comb begin
        do_prime   = (state_reg == PRIME);
        do_compare = (state_reg == RUN) && i_en;
    end

    // ------------------------------------------------------- change detect
    assign cur      = {p.z, p.y, p.x};
    assign diff     = cur ^ s_reg;
    assign evt      = do_compare && (diff != 3'b000);
    assign evt_data = {s_reg, cur};

    // s follows the interface on every event, even when the event is dropped,
    // so the next event describes the transition actually seen.
    always_ff @(posedge i_clk) begin
        if (i_srst)                s_reg <= 3'b000;
        else if (do_prime || evt)  s_reg <= cur;
    end

    // --------------------------------------------------------------- FIFO
    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (level == (AW+1)'(DEPTH));
    assign pop         = !empty && i_evt_ready;
    assign push        = evt && (!full || pop);
    assign drop        = evt && full && !pop;
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= evt_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, push};
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Registered head: when the entry being written this cycle becomes the
    // next head (empty FIFO, or last entry popped), forward it around the RAM.
    always_ff @(posedge i_clk) begin
        if (i_srst)
            head_reg <= 6'd0;
        else if (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
            head_reg <= evt_data;
        else
            head_reg <= mem[rd_ptr_next[AW-1:0]];
    end

    assign o_evt_valid = !empty;
    assign o_evt_data  = head_reg;

    // ----------------------------------------------------------- overflow
    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) overflow_reg <= 1'b0;
        else if (drop)       overflow_reg <= 1'b1;
    end

    assign o_overflow = overflow_reg;

    // ----------------------------------------------------------- counters
`ifdef SVI_READER_COUNT_EN
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        // Counts every detected toggle, including those whose event is dropped.
        always_ff @(posedge i_clk) begin
            if (i_srst || i_clr)
                cnt_reg <= '0;
            else if (evt && diff[gi] && (cnt_reg != {CNT_W{1'b1}}))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end

        assign cnt_bus[gi] = cnt_reg;
    end
`else
    assign cnt_bus = '0;
`endif

    assign o_cnt_z = cnt_bus[2];
    assign o_cnt_y = cnt_bus[1];
    assign o_cnt_x = cnt_bus[0];

endmodule

// File: tb/tb_svi_scalar_reader.sv
// -----------------------------------------------------------------------------
// tb_svi_scalar_reader -- directed, table-driven bench for svi_scalar_reader
// (DEPTH=4, CNT_W=2). Each vector gives the inputs applied before a rising
// edge and the outputs expected just after it.
// -----------------------------------------------------------------------------
module tb_svi_scalar_reader;

    logic       clk = 1'b0;
    logic       srst, en, clr, evt_ready;
    logic       evt_valid, overflow;
    logic [5:0] evt_data;
    logic [1:0] cnt_z, cnt_y, cnt_x;

    int checks = 0;
    int errors = 0;

    I ifc ();

    svi_scalar_reader #(.DEPTH(4), .CNT_W(2)) dut (
        .i_clk       (clk),
        .i_srst      (srst),
        .p           (ifc.R),
        .i_en        (en),
        .i_clr       (clr),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_data  (evt_data),
        .o_cnt_z     (cnt_z),
        .o_cnt_y     (cnt_y),
        .o_cnt_x     (cnt_x),
        .o_overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       srst, en, rdy, clr;
        logic [2:0] zyx;
        logic       ev;
        logic [5:0] ed;
        logic [1:0] cz, cy, cx;
        logic       ov;
    } vec_t;

    vec_t tbl[$];
    int   vec_no = 0;

    function automatic vec_t mk(input logic s, input logic e, input logic r,
                                input logic c, input logic [2:0] zyx,
                                input logic ev, input logic [5:0] ed,
                                input logic [1:0] cz, input logic [1:0] cy,
                                input logic [1:0] cx, input logic ov);
        vec_t v;
        v.srst = s; v.en = e; v.rdy = r; v.clr = c; v.zyx = zyx;
        v.ev = ev; v.ed = ed; v.cz = cz; v.cy = cy; v.cx = cx; v.ov = ov;
        return v;
    endfunction

    // Counters exist only when the design is built with them.
    function automatic logic [1:0] ecnt(input logic [1:0] c);
`ifdef SVI_READER_COUNT_EN
        return c;
`else
        return (c & 2'b00);
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL vec%0d %s: got %0h expected %0h", vec_no, name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        srst = v.srst; en = v.en; evt_ready = v.rdy; clr = v.clr;
        ifc.z = v.zyx[2]; ifc.y = v.zyx[1]; ifc.x = v.zyx[0];
        @(posedge clk);
        #1;
        chk("valid",    {7'd0, evt_valid}, {7'd0, v.ev});
        if (v.ev) chk("data", {2'd0, evt_data}, {2'd0, v.ed});
        chk("cnt_z",    {6'd0, cnt_z}, {6'd0, ecnt(v.cz)});
        chk("cnt_y",    {6'd0, cnt_y}, {6'd0, ecnt(v.cy)});
        chk("cnt_x",    {6'd0, cnt_x}, {6'd0, ecnt(v.cx)});
        chk("overflow", {7'd0, overflow}, {7'd0, v.ov});
        $display("vec%0d zyx=%b en=%b rdy=%b clr=%b srst=%b -> valid=%b data=%b cnt=%0d/%0d/%0d ovf=%b",
                 vec_no, v.zyx, v.en, v.rdy, v.clr, v.srst,
                 evt_valid, evt_data, cnt_z, cnt_y, cnt_x, overflow);
        vec_no++;
    endtask

    initial begin
        srst = 1'b1; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        ifc.z = 1'b1; ifc.y = 1'b0; ifc.x = 1'b1;

        // reset
        tbl.push_back(mk(1,0,0,0,3'b101, 0,6'o00, 0,0,0, 0));
        tbl.push_back(mk(1,0,0,0,3'b101, 0,6'o00, 0,0,0, 0));
        // enable with a static interface: prime, then no events
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0,1,1,0,3'b101, 0,6'o00, 0,0,0, 0));
        // x 1->0, accepted next cycle
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b101100, 0,0,1, 0));
        tbl.push_back(mk(0,1,1,0,3'b100, 0,6'o00,     0,0,1, 0));
        // ready low: fill the FIFO, x counter saturates at 3
        tbl.push_back(mk(0,1,0,0,3'b101, 1,6'b100101, 0,0,2, 0));
        tbl.push_back(mk(0,1,0,0,3'b100, 1,6'b100101, 0,0,3, 0));
        tbl.push_back(mk(0,1,0,0,3'b101, 1,6'b100101, 0,0,3, 0));
        tbl.push_back(mk(0,1,0,0,3'b100, 1,6'b100101, 0,0,3, 0));
        // full + pop + push same cycle: accepted, no overflow
        tbl.push_back(mk(0,1,1,0,3'b101, 1,6'b101100, 0,0,3, 0));
        // full, no pop: dropped, overflow sticks
        tbl.push_back(mk(0,1,0,0,3'b100, 1,6'b101100, 0,0,3, 1));
        // drain in order
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b100101, 0,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b101100, 0,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b100101, 0,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b100, 0,6'o00,     0,0,3, 1));
        // z toggles, single-entry push+pop stream, saturation, then clear
        tbl.push_back(mk(0,1,1,0,3'b000, 1,6'b100000, 1,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b000100, 2,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b000, 1,6'b100000, 3,0,3, 1));
        tbl.push_back(mk(0,1,1,0,3'b100, 1,6'b000100, 3,0,3, 1));
        tbl.push_back(mk(0,1,1,1,3'b000, 1,6'b100000, 0,0,0, 0));
        tbl.push_back(mk(0,1,1,0,3'b000, 0,6'o00,     0,0,0, 0));
        // queue three y events
        tbl.push_back(mk(0,1,0,0,3'b010, 1,6'b000010, 0,1,0, 0));
        tbl.push_back(mk(0,1,0,0,3'b000, 1,6'b000010, 0,2,0, 0));
        tbl.push_back(mk(0,1,0,0,3'b010, 1,6'b000010, 0,3,0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            if (i == 1) chk("reset_data", {2'd0, evt_data}, 8'd0);
        end

        // reset mid-operation with three events queued
        apply(mk(1,1,0,0,3'b010, 0,6'o00, 0,0,0, 0));
        chk("srst_data", {2'd0, evt_data}, 8'd0);
        // enable: IDLE->PRIME, prime, then first compare on the second edge
        apply(mk(0,1,0,0,3'b011, 0,6'o00,     0,0,0, 0));
        apply(mk(0,1,0,0,3'b011, 0,6'o00,     0,0,0, 0));
        apply(mk(0,1,0,0,3'b111, 1,6'b011111, 1,0,0, 0));
        // drop enable while the interface changes: no compare, pop the event
        apply(mk(0,0,1,0,3'b011, 0,6'o00,     1,0,0, 0));
        // re-enable: passes through PRIME, changes before prime are not events
        apply(mk(0,1,1,0,3'b001, 0,6'o00,     1,0,0, 0));
        apply(mk(0,1,1,0,3'b000, 0,6'o00,     1,0,0, 0));
        apply(mk(0,1,1,0,3'b000, 0,6'o00,     1,0,0, 0));
        apply(mk(0,1,1,0,3'b100, 1,6'b000100, 2,0,0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
